// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the 7-way bus arbiter
package arb_pkg;

    localparam int NUM_REQ = 7;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick7.sv
// rtl/rr_pick7.sv - rotating-priority search over 7 requesters
module rr_pick7
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_owner,
    output logic               found,
    output logic [SEL_W-1:0]   index
);

    logic [3:0] cand;

    // Scan from farthest to nearest so the nearest hit after last_owner wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_owner} + 4'(i);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (req[cand[2:0]]) begin
                found = 1'b1;
                index = cand[2:0];
            end
        end
    end

endmodule

// File: rtl/arb7_ctrl.sv
// rtl/arb7_ctrl.sv - round-robin owner of a shared 8-bit bus with burst cap
module arb7_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_BEATS = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   select,
    output logic               bus_valid,
    output logic [7:0]         beat
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic               bus_valid_q, bus_valid_d;
    logic [7:0]         beat_q, beat_d;
    logic [SEL_W-1:0]   last_owner_q, last_owner_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_req;

    rr_pick7 u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    assign owner_req = |(gnt_q & req);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        select_d     = select_q;
        bus_valid_d  = bus_valid_q;
        beat_d       = beat_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                select_d    = '0;
                bus_valid_d = 1'b0;
                beat_d      = '0;
                if (pick_found) begin
                    state_d           = GRANT;
                    gnt_d[pick_idx]   = 1'b1;
                    select_d          = pick_idx;
                    bus_valid_d       = 1'b1;
                    last_owner_d      = pick_idx;
                end
            end
            GRANT: begin
                // Release always passes through IDLE, giving the one-cycle gap.
                if (!owner_req || beat_q == LAST_BEAT) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    select_d    = '0;
                    bus_valid_d = 1'b0;
                    beat_d      = '0;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                select_d    = '0;
                bus_valid_d = 1'b0;
                beat_d      = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            select_q     <= '0;
            bus_valid_q  <= 1'b0;
            beat_q       <= '0;
            last_owner_q <= 3'd6;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            select_q     <= select_d;
            bus_valid_q  <= bus_valid_d;
            beat_q       <= beat_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign gnt       = gnt_q;
    assign select    = select_q;
    assign bus_valid = bus_valid_q;
    assign beat      = beat_q;

endmodule

// File: tb/tb_arb7_ctrl.sv
// tb/tb_arb7_ctrl.sv - self-checking bench for arb7_ctrl at MAX_BEATS 8, 2 and 1
module tb_arb7_ctrl;

    typedef struct packed {
        logic [6:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic [7:0] beat;
    } out_t;

    typedef struct {
        logic [6:0] req;
        out_t       exp;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [6:0] req = '0;

    logic [6:0] gnt8, gnt2, gnt1;
    logic [2:0] sel8, sel2, sel1;
    logic       v8, v2, v1;
    logic [7:0] beat8, beat2, beat1;

    out_t obs [3];
    assign obs[0] = {gnt8, sel8, v8, beat8};
    assign obs[1] = {gnt2, sel2, v2, beat2};
    assign obs[2] = {gnt1, sel1, v1, beat1};

    arb7_ctrl #(.MAX_BEATS(8)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .gnt(gnt8), .select(sel8), .bus_valid(v8), .beat(beat8)
    );
    arb7_ctrl #(.MAX_BEATS(2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .gnt(gnt2), .select(sel2), .bus_valid(v2), .beat(beat2)
    );
    arb7_ctrl #(.MAX_BEATS(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .gnt(gnt1), .select(sel1), .bus_valid(v1), .beat(beat1)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    int maxb    [3] = '{8, 2, 1};
    int m_owner [3];
    int m_beats [3];
    int m_last  [3];

    int prev_valid [3];
    int run_len    [3];
    int waits      [3][7];

    function automatic out_t model_out(input int k);
        out_t o;
        o = '0;
        if (m_owner[k] >= 0) begin
            o.gnt   = 7'(1 << m_owner[k]);
            o.sel   = 3'(m_owner[k]);
            o.valid = 1'b1;
            o.beat  = 8'(m_beats[k]);
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k]    = -1;
            m_beats[k]    = 0;
            m_last[k]     = 6;
            prev_valid[k] = 0;
            run_len[k]    = 0;
            for (int i = 0; i < 7; i++) waits[k][i] = 0;
        end
    endtask

    task automatic model_edge(input logic [6:0] r);
        for (int k = 0; k < 3; k++) begin
            if (m_owner[k] < 0) begin
                for (int d = 1; d <= 7; d++) begin
                    int c;
                    c = (m_last[k] + d) % 7;
                    if (m_owner[k] < 0 && r[c]) begin
                        m_owner[k] = c;
                        m_beats[k] = 0;
                        m_last[k]  = c;
                    end
                end
            end else if (!r[m_owner[k]] || m_beats[k] + 1 >= maxb[k]) begin
                m_owner[k] = -1;
            end else begin
                m_beats[k]++;
            end
        end
    endtask

    task automatic cmp(input string tag, input int k, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got gnt=%b sel=%0d valid=%b beat=%0d want gnt=%b sel=%0d valid=%b beat=%0d",
                     tag, k, got.gnt, got.sel, got.valid, got.beat,
                     exp.gnt, exp.sel, exp.valid, exp.beat);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] r);
        for (int k = 0; k < 3; k++) begin
            cmp({tag, "_model"}, k, obs[k], model_out(k));
            checks++;
            if (!$onehot0(obs[k].gnt) || obs[k].sel > 3'd6) begin
                errors++;
                $display("FAIL onehot_sel dut%0d got gnt=%b sel=%0d want onehot0 gnt and sel<=6",
                         k, obs[k].gnt, obs[k].sel);
            end
            if (obs[k].valid) begin
                if (prev_valid[k] == 0) begin
                    run_len[k] = 1;
                    for (int i = 0; i < 7; i++) begin
                        if (i == int'(obs[k].sel)) waits[k][i] = 0;
                        else if (r[i])             waits[k][i]++;
                        else                       waits[k][i] = 0;
                        checks++;
                        if (waits[k][i] > 6) begin
                            errors++;
                            $display("FAIL starvation dut%0d req%0d waited %0d grants want <=6",
                                     k, i, waits[k][i]);
                        end
                    end
                end else begin
                    run_len[k]++;
                end
                checks++;
                if (run_len[k] > maxb[k]) begin
                    errors++;
                    $display("FAIL burst_len dut%0d got %0d cycles want <=%0d",
                             k, run_len[k], maxb[k]);
                end
            end
            prev_valid[k] = obs[k].valid ? 1 : 0;
        end
    endtask

    task automatic step(input logic [6:0] r, input string tag);
        @(negedge Clk);
        req = r;
        @(posedge Clk);
        model_edge(r);
        #1;
        check_all(tag, r);
    endtask

    // Reset is applied away from any clock edge and must clear outputs immediately.
    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        req     = '0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) cmp({tag, "_async"}, k, obs[k], '0);
        @(posedge Clk);
        #1;
        for (int k = 0; k < 3; k++) cmp({tag, "_held"}, k, obs[k], '0);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    function automatic out_t mk(input int idx, input int b);
        out_t o;
        o       = '0;
        o.gnt   = 7'(1 << idx);
        o.sel   = 3'(idx);
        o.valid = 1'b1;
        o.beat  = 8'(b);
        return o;
    endfunction

    vec_t tbl [12];

    initial begin
        logic [6:0] r;
        out_t       e;
        int         pos;

        tbl[0]  = '{7'b0000100, mk(2, 0)};
        tbl[1]  = '{7'b0000100, mk(2, 1)};
        tbl[2]  = '{7'b0000100, mk(2, 2)};
        tbl[3]  = '{7'b0000000, out_t'(0)};
        tbl[4]  = '{7'b0100000, mk(5, 0)};
        tbl[5]  = '{7'b1100010, mk(5, 1)};
        tbl[6]  = '{7'b1100010, mk(5, 2)};
        tbl[7]  = '{7'b1000010, out_t'(0)};
        tbl[8]  = '{7'b1000010, mk(6, 0)};
        tbl[9]  = '{7'b0000010, out_t'(0)};
        tbl[10] = '{7'b0000010, mk(1, 0)};
        tbl[11] = '{7'b0000000, out_t'(0)};

        model_reset();
        do_reset("reset0");

        // All requesters busy: dut2 rotates 0..6,0 with 2-beat grants, dut1 with 1-beat grants.
        for (int k = 0; k < 24; k++) begin
            step(7'h7F, "all_req");
            pos = k % 3;
            e = (pos == 2) ? out_t'(0) : mk((k / 3) % 7, pos);
            cmp("rr_max2", 1, obs[1], e);
            e = (k % 2 == 1) ? out_t'(0) : mk((k / 2) % 7, 0);
            cmp("rr_max1", 2, obs[2], e);
        end

        do_reset("reset1");
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, "table");
            cmp($sformatf("table%0d", i), 0, obs[0], tbl[i].exp);
        end

        // Lone requester 3 for 20 cycles: capped, one idle cycle, regranted from beat 0.
        for (int k = 0; k < 20; k++) begin
            step(7'b0001000, "cap");
            pos = k % 9;
            e = (pos == 8) ? out_t'(0) : mk(3, pos);
            cmp("cap_max8", 0, obs[0], e);
            e = (k % 3 == 2) ? out_t'(0) : mk(3, k % 3);
            cmp("cap_max2", 1, obs[1], e);
            e = (k % 2 == 1) ? out_t'(0) : mk(3, 0);
            cmp("cap_max1", 2, obs[2], e);
        end
        step(7'b0000000, "cap_drop");
        cmp("cap_drop", 0, obs[0], '0);

        do_reset("reset2");
        for (int b = 0; b < 4; b++) begin
            step(7'b0010000, "pre_abort");
            cmp("pre_abort", 0, obs[0], mk(4, b));
        end
        do_reset("abort");
        step(7'h7F, "post_abort");
        for (int k = 0; k < 3; k++) cmp("post_abort_first", k, obs[k], mk(0, 0));

        r = 7'h7F;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 15) == 0) r[i] = ~r[i];
            end
            if ($urandom_range(0, 199) == 0) r = '0;
            step(r, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
